// File: rtl/mxint_quantizer.sv
// Two-stage valid/ready quantizer from signed fixed point to MXINT (mantissas + shared exponent).
// Define MXINT_QUANTIZER_ROUND_EN for round-half-up; otherwise mantissas are truncated (floor).
module mxint_quantizer #(
  parameter int unsigned IN_WIDTH      = 16,
  parameter int unsigned IN_FRAC_WIDTH = 8,
  parameter int unsigned OUT_MAN_WIDTH = 8,
  parameter int unsigned OUT_EXP_WIDTH = 4,
  parameter int unsigned BLOCK_SIZE    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [IN_WIDTH-1:0]      data_in        [BLOCK_SIZE],
  input  logic                            data_in_valid,
  output logic                            data_in_ready,
  output logic signed [OUT_MAN_WIDTH-1:0] mdata_out      [BLOCK_SIZE],
  output logic        [OUT_EXP_WIDTH-1:0] edata_out,
  output logic                            data_out_valid,
  input  logic                            data_out_ready
);

  localparam int          Bias = int'(2 ** (OUT_EXP_WIDTH - 1)) - 1;
  localparam int          SMin = int'(IN_FRAC_WIDTH) - Bias;
  localparam int          SMax = SMin + int'(2 ** OUT_EXP_WIDTH) - 1;
  localparam int unsigned Ww   = IN_WIDTH + OUT_MAN_WIDTH + 1;
  localparam int unsigned Pw   = $clog2(IN_WIDTH);

  localparam logic signed [Ww-1:0] ManMax = (Ww'(1) << (OUT_MAN_WIDTH - 1)) - Ww'(1);
  localparam logic signed [Ww-1:0] ManMin = -(Ww'(1) << (OUT_MAN_WIDTH - 1));

  logic                            v1_q, v2_q;
  logic signed [IN_WIDTH-1:0]      d1_q    [BLOCK_SIZE];
  logic        [Pw-1:0]            p_q, p_d;
  logic signed [OUT_MAN_WIDTH-1:0] mdata_q [BLOCK_SIZE];
  logic signed [OUT_MAN_WIDTH-1:0] mdata_d [BLOCK_SIZE];
  logic        [OUT_EXP_WIDTH-1:0] edata_q, edata_d;
  logic        [IN_WIDTH-1:0]      mag_or;
  logic signed [Ww-1:0]            ext, shifted;
  int                              s_c;
  logic                            stage1_ready, stage2_ready;

  assign stage2_ready  = !v2_q || data_out_ready;
  assign stage1_ready  = !v1_q || stage2_ready;
  // Gated by rst so the port reads 0 while reset is held, 1 as soon as it releases.
  assign data_in_ready = rst && stage1_ready;

  // Stage 1: leading-one position of the OR of magnitudes (~d for negatives).
  always_comb begin
    mag_or = '0;
    for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
      mag_or = mag_or | (data_in[i][IN_WIDTH-1] ? ~data_in[i] : data_in[i]);
    end
    p_d = '0;
    for (int b = 0; b < int'(IN_WIDTH); b++) begin
      if (mag_or[b]) p_d = Pw'(b);
    end
  end

  // Stage 2: clamp shift, scale each element, saturate to the mantissa range.
  always_comb begin
    s_c = int'(p_q) - (int'(OUT_MAN_WIDTH) - 2);
    if (s_c < SMin) s_c = SMin;
    else if (s_c > SMax) s_c = SMax;
    edata_d = OUT_EXP_WIDTH'(s_c - int'(IN_FRAC_WIDTH) + Bias);
    ext     = '0;
    shifted = '0;
    for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
      ext = Ww'(d1_q[i]);
      if (s_c > 0) begin
`ifdef MXINT_QUANTIZER_ROUND_EN
        ext = ext + (Ww'(1) << (s_c - 1));
`endif
        shifted = ext >>> s_c;
      end else begin
        shifted = ext <<< (-s_c);
      end
      if (shifted > ManMax)      mdata_d[i] = ManMax[OUT_MAN_WIDTH-1:0];
      else if (shifted < ManMin) mdata_d[i] = ManMin[OUT_MAN_WIDTH-1:0];
      else                       mdata_d[i] = shifted[OUT_MAN_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      p_q     <= '0;
      d1_q    <= '{default: '0};
      mdata_q <= '{default: '0};
      edata_q <= '0;
    end else begin
      if (stage1_ready) v1_q <= data_in_valid;
      if (stage1_ready && data_in_valid) begin
        d1_q <= data_in;
        p_q  <= p_d;
      end
      if (stage2_ready) v2_q <= v1_q;
      if (stage2_ready && v1_q) begin
        mdata_q <= mdata_d;
        edata_q <= edata_d;
      end
    end
  end

  assign mdata_out      = mdata_q;
  assign edata_out      = edata_q;
  assign data_out_valid = v2_q;

endmodule

// File: tb/tb_mxint_quantizer.sv
// Self-checking bench for mxint_quantizer: directed vectors, random traffic vs. a value model,
// backpressure capacity and asynchronous mid-stream reset.
module tb_mxint_quantizer;

  localparam int InW  = 16;
  localparam int Frac = 8;
  localparam int ManW = 8;
  localparam int ExpW = 4;
  localparam int Bs   = 4;
  localparam int Bias = 2 ** (ExpW - 1) - 1;
  localparam int SLo  = Frac - Bias;
  localparam int SHi  = SLo + 2 ** ExpW - 1;

  typedef logic signed [InW-1:0] blk_t [Bs];
  typedef struct {
    int m [Bs];
    int e;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic signed [InW-1:0]  data_in [Bs];
  logic                   data_in_valid = 1'b0;
  logic                   data_in_ready;
  logic signed [ManW-1:0] mdata_out [Bs];
  logic        [ExpW-1:0] edata_out;
  logic                   data_out_valid;
  logic                   data_out_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mxint_quantizer #(
    .IN_WIDTH     (InW),
    .IN_FRAC_WIDTH(Frac),
    .OUT_MAN_WIDTH(ManW),
    .OUT_EXP_WIDTH(ExpW),
    .BLOCK_SIZE   (Bs)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .mdata_out     (mdata_out),
    .edata_out     (edata_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Value-level reference: scale by 2^-s, floor (or round half up), clamp to mantissa range.
  function automatic exp_t model(input blk_t d);
    exp_t   r;
    longint v, mag, maxmag, num, q;
    int     p, s;
    maxmag = 0;
    for (int i = 0; i < Bs; i++) begin
      v   = longint'(d[i]);
      mag = (v < 0) ? -v - 1 : v;
      if (mag > maxmag) maxmag = mag;
    end
    p = 0;
    while ((longint'(1) << (p + 1)) <= maxmag) p++;
    s = p - (ManW - 2);
    if (s < SLo) s = SLo;
    if (s > SHi) s = SHi;
    for (int i = 0; i < Bs; i++) begin
      v = longint'(d[i]);
      if (s > 0) begin
        num = v;
`ifdef MXINT_QUANTIZER_ROUND_EN
        num = num + (longint'(1) << (s - 1));
`endif
        q = floor_div(num, longint'(1) << s);
      end else begin
        q = v * (longint'(1) << (-s));
      end
      if (q > 2 ** (ManW - 1) - 1) q = 2 ** (ManW - 1) - 1;
      if (q < -(2 ** (ManW - 1))) q = -(2 ** (ManW - 1));
      r.m[i] = int'(q);
    end
    r.e = s - Frac + Bias;
    return r;
  endfunction

  function automatic logic signed [InW-1:0] rand_elem();
    logic [InW-1:0] v;
    v = InW'($urandom >> $urandom_range(16, 31));
    if ($urandom_range(0, 1) == 1) v = ~v;
    return v;
  endfunction

  task automatic test_reset();
    logic bad;
    rst = 1'b0;
    data_in = '{default: '0};
    repeat (2) @(negedge clk);
    #1;
    bad = (data_out_valid !== 1'b0) || (edata_out !== '0) || (data_in_ready !== 1'b0);
    for (int i = 0; i < Bs; i++) if (mdata_out[i] !== '0) bad = 1'b1;
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b ready=%b e=%0d m0=%0d, want all 0",
               data_out_valid, data_in_ready, edata_out, mdata_out[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (data_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b, want 1", data_in_ready);
    end
  endtask

  task automatic test_directed();
    blk_t tab [4];
    exp_t want [4];
    logic bad;
    tab[0] = '{16'sh0100, 16'sh0080, -16'sh0100, 16'sh0000};
    tab[1] = '{16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000};
    tab[2] = '{16'sh0001, 16'sh0001, 16'sh0001, 16'sh0001};
    tab[3] = '{16'sh7FFF, 16'sh0000, 16'sh0000, 16'sh0000};
    want[0] = '{m: '{64, 32, -64, 0}, e: 1};
    want[1] = '{m: '{0, 0, 0, 0}, e: 0};
`ifdef MXINT_QUANTIZER_ROUND_EN
    want[2] = '{m: '{1, 1, 1, 1}, e: 0};
`else
    want[2] = '{m: '{0, 0, 0, 0}, e: 0};
`endif
    want[3] = '{m: '{127, 0, 0, 0}, e: 7};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      data_in = tab[k];
      data_in_valid = 1'b1;
      data_out_ready = 1'b1;
      @(negedge clk);
      data_in_valid = 1'b0;
      #1;
      n_vec++;
      if (data_out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL dir%0d_early_valid: got %b, want 0 one edge after accept", k,
                 data_out_valid);
      end
      @(negedge clk);
      #1;
      bad = (data_out_valid !== 1'b1) || (int'(edata_out) !== want[k].e);
      for (int i = 0; i < Bs; i++) if (int'(mdata_out[i]) !== want[k].m[i]) bad = 1'b1;
      n_vec++;
      if (bad) begin
        n_err++;
        $display("FAIL dir%0d_block: got v=%b m={%0d,%0d,%0d,%0d} e=%0d, want m={%0d,%0d,%0d,%0d} e=%0d",
                 k, data_out_valid, mdata_out[0], mdata_out[1], mdata_out[2], mdata_out[3],
                 edata_out, want[k].m[0], want[k].m[1], want[k].m[2], want[k].m[3], want[k].e);
      end
    end
  endtask

  task automatic test_random(input int n_cycles);
    exp_t q[$];
    exp_t w;
    logic bad;
    int   budget;
    for (int c = 0; c < n_cycles + 40; c++) begin
      if (c >= n_cycles && q.size() == 0) break;
      @(negedge clk);
      if (c < n_cycles) begin
        data_in_valid = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < Bs; i++) data_in[i] = rand_elem();
        if ($urandom_range(0, 7) == 0) data_in = '{default: '0};
        data_out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        data_in_valid = 1'b0;
        data_out_ready = 1'b1;
      end
      #1;
      n_vec++;
      if (data_in_ready !== ((q.size() < 2) || data_out_ready)) begin
        n_err++;
        $display("FAIL rand_ready: got %b, want %b (held=%0d)", data_in_ready,
                 (q.size() < 2) || data_out_ready, q.size());
      end
      if (data_out_valid === 1'b1 && data_out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra_block: got unexpected output, want none");
        end else begin
          w = q.pop_front();
          bad = (int'(edata_out) !== w.e);
          for (int i = 0; i < Bs; i++) if (int'(mdata_out[i]) !== w.m[i]) bad = 1'b1;
          if (bad) begin
            n_err++;
            $display("FAIL rand_block: got m={%0d,%0d,%0d,%0d} e=%0d, want m={%0d,%0d,%0d,%0d} e=%0d",
                     mdata_out[0], mdata_out[1], mdata_out[2], mdata_out[3], edata_out,
                     w.m[0], w.m[1], w.m[2], w.m[3], w.e);
          end
        end
      end
      if (data_in_valid && data_in_ready) q.push_back(model(data_in));
    end
    budget = q.size();
    n_vec++;
    if (budget != 0) begin
      n_err++;
      $display("FAIL rand_drain: got %0d blocks still pending, want 0", budget);
    end
  endtask

  task automatic test_backpressure();
    blk_t b [3];
    exp_t w [3];
    logic bad;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < Bs; i++) b[k][i] = rand_elem();
      w[k] = model(b[k]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      data_in = b[k];
      data_in_valid = 1'b1;
      data_out_ready = 1'b0;
      #1;
      n_vec++;
      if (data_in_ready !== (k < 2)) begin
        n_err++;
        $display("FAIL bp_ready%0d: got %b, want %b", k, data_in_ready, k < 2);
      end
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j == 0) data_out_ready = 1'b1;
      if (j == 1) data_in_valid = 1'b0;
      #1;
      if (j == 3) begin
        bad = (data_out_valid !== 1'b0);
      end else begin
        bad = (data_out_valid !== 1'b1) || (int'(edata_out) !== w[j].e);
        for (int i = 0; i < Bs; i++) if (int'(mdata_out[i]) !== w[j].m[i]) bad = 1'b1;
      end
      n_vec++;
      if (bad) begin
        n_err++;
        $display("FAIL bp_out%0d: got v=%b m={%0d,%0d,%0d,%0d} e=%0d, want block %0d in order",
                 j, data_out_valid, mdata_out[0], mdata_out[1], mdata_out[2], mdata_out[3],
                 edata_out, j);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic bad;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      for (int i = 0; i < Bs; i++) data_in[i] = rand_elem();
      data_in[0] = 16'sh4000;
      data_in_valid = 1'b1;
      data_out_ready = 1'b0;
    end
    @(negedge clk);
    data_in_valid = 1'b0;
    #1;
    n_vec++;
    if (data_out_valid !== 1'b1 || data_in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_full: got valid=%b ready=%b, want 1 0", data_out_valid, data_in_ready);
    end
    #1 rst = 1'b0;
    #1;
    bad = (data_out_valid !== 1'b0) || (edata_out !== '0) || (data_in_ready !== 1'b0);
    for (int i = 0; i < Bs; i++) if (mdata_out[i] !== '0) bad = 1'b1;
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL mid_async_clear: got valid=%b ready=%b e=%0d m0=%0d, want all 0",
               data_out_valid, data_in_ready, edata_out, mdata_out[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    data_out_ready = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (data_out_valid !== 1'b0 || data_in_ready !== 1'b1) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL mid_stale_block: got valid=%b ready=%b after release, want 0 1",
               data_out_valid, data_in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(3000);
    test_backpressure();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
